// File: rtl/tx_iq_intf_mc.sv
// Multi-channel TX I/Q interface: per-channel gain with rounding, lockstep FWFT FIFO, s_axis bypass,
// tx_hold hysteresis and overflow/underrun counters. Define TX_IQ_INTF_MC_SAT_EN to saturate instead of wrap.
module tx_iq_intf_mc #(
   parameter int IQ_DATA_WIDTH          = 16,
   parameter int NUM_CH                 = 2,
   parameter int GAIN_WIDTH             = 10,
   parameter int GAIN_SHIFT             = 7,
   parameter int FIFO_ADDR_WIDTH        = 9,
   parameter int C_S00_AXIS_TDATA_WIDTH = 64
) (
   input  logic                                clk,
   input  logic                                rstn,
   input  logic [NUM_CH*IQ_DATA_WIDTH-1:0]     rf_i,
   input  logic [NUM_CH*IQ_DATA_WIDTH-1:0]     rf_q,
   input  logic                                rf_iq_valid,
   input  logic [NUM_CH*GAIN_WIDTH-1:0]        bb_gain,
   input  logic                                src_sel,
   input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]   data_from_s_axis,
   input  logic                                emptyn_from_s_axis,
   output logic                                ask_data_from_s_axis,
   output logic [NUM_CH*2*IQ_DATA_WIDTH-1:0]   wifi_iq_pack,
   output logic                                wifi_iq_valid,
   input  logic                                wifi_iq_ready,
   input  logic [FIFO_ADDR_WIDTH:0]            tx_hold_thr_hi,
   input  logic [FIFO_ADDR_WIDTH:0]            tx_hold_thr_lo,
   output logic                                tx_hold,
   output logic                                tx_iq_fifo_empty,
   output logic [FIFO_ADDR_WIDTH:0]            data_count,
   output logic [15:0]                         overflow_count,
   output logic [15:0]                         underrun_count
);

   localparam int PW    = IQ_DATA_WIDTH + GAIN_WIDTH;
   localparam int WW    = NUM_CH * 2 * IQ_DATA_WIDTH;
   localparam int AW    = FIFO_ADDR_WIDTH;
   localparam int DEPTH = 1 << AW;

   localparam logic signed [PW-1:0] HALF       = PW'(1) <<< (GAIN_SHIFT - 1);
   localparam logic [AW:0]          COUNT_FULL = {1'b1, {AW{1'b0}}};
   localparam logic [AW:0]          CNT_ONE    = (AW + 1)'(1);
   localparam logic [AW-1:0]        PTR_ONE    = AW'(1);
`ifdef TX_IQ_INTF_MC_SAT_EN
   localparam logic signed [PW-1:0] SAT_MAX = {{(PW-IQ_DATA_WIDTH+1){1'b0}}, {(IQ_DATA_WIDTH-1){1'b1}}};
   localparam logic signed [PW-1:0] SAT_MIN = {{(PW-IQ_DATA_WIDTH+1){1'b1}}, {(IQ_DATA_WIDTH-1){1'b0}}};
`endif

   // Scaled samples for all lanes; lane 2k is ch k I, lane 2k+1 is ch k Q, matching the pack layout.
   logic [WW-1:0]   r_all;
   logic [WW-1:0]   wdata_q;
   logic            valid1_q, valid1_d;
   logic            wren_q, wren_d;

   logic [WW-1:0]   fifo_mem [DEPTH];
   logic [WW-1:0]   rd_data_q;
   logic [WW-1:0]   byp_data_q;
   logic            byp_q, byp_d;
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [AW:0]     count_q, count_d;
   logic            primed_q, primed_d;
   logic            hold_q, hold_d;
   logic            sel1_q, sel2_q;
   logic [15:0]     ovf_q, ovf_d;
   logic [15:0]     unr_q, unr_d;

   logic            empty, full, flush, rden, wr_acc, drop, underrun;
   logic [WW-1:0]   head;

   genvar gi;
   generate
      for (gi = 0; gi < 2*NUM_CH; gi++) begin : g_lane
         logic signed [IQ_DATA_WIDTH-1:0] samp;
         logic signed [GAIN_WIDTH-1:0]    gain;
         logic signed [PW-1:0]            prod_d;
         logic signed [PW-1:0]            prod_q;
         logic signed [PW-1:0]            rnd;
         logic        [IQ_DATA_WIDTH-1:0] r_lane;

         if (gi % 2 == 0) begin : g_i
            assign samp = rf_i[(gi/2)*IQ_DATA_WIDTH +: IQ_DATA_WIDTH];
         end else begin : g_q
            assign samp = rf_q[(gi/2)*IQ_DATA_WIDTH +: IQ_DATA_WIDTH];
         end
         assign gain = bb_gain[(gi/2)*GAIN_WIDTH +: GAIN_WIDTH];

         assign prod_d = $signed({{GAIN_WIDTH{samp[IQ_DATA_WIDTH-1]}}, samp}) *
                         $signed({{IQ_DATA_WIDTH{gain[GAIN_WIDTH-1]}}, gain});

         always_ff @(posedge clk) begin
            prod_q <= prod_d;
         end

         // Round half up, then floor-shift the fractional gain bits away.
         assign rnd = prod_q + HALF;

`ifdef TX_IQ_INTF_MC_SAT_EN
         logic signed [PW-1:0] sh;
         logic                 unused_bits;
         assign sh          = rnd >>> GAIN_SHIFT;
         assign unused_bits = ^rnd[GAIN_SHIFT-1:0];
         always_comb begin
            r_lane = sh[IQ_DATA_WIDTH-1:0];
            if (sh > SAT_MAX) begin
               r_lane = SAT_MAX[IQ_DATA_WIDTH-1:0];
            end else if (sh < SAT_MIN) begin
               r_lane = SAT_MIN[IQ_DATA_WIDTH-1:0];
            end
         end
`else
         logic unused_bits;
         assign r_lane      = rnd[GAIN_SHIFT +: IQ_DATA_WIDTH];
         assign unused_bits = ^{rnd[PW-1:GAIN_SHIFT+IQ_DATA_WIDTH], rnd[GAIN_SHIFT-1:0]};
`endif

         assign r_all[gi*IQ_DATA_WIDTH +: IQ_DATA_WIDTH] = r_lane;
      end

      if (C_S00_AXIS_TDATA_WIDTH > WW) begin : g_axis_unused
         logic unused_axis;
         assign unused_axis = ^data_from_s_axis[C_S00_AXIS_TDATA_WIDTH-1:WW];
      end
   endgenerate

   assign empty    = (count_q == '0);
   assign full     = (count_q == COUNT_FULL);
   assign flush    = sel1_q ^ sel2_q;
   assign rden     = ~src_sel & wifi_iq_ready & ~empty & ~flush;
   assign wr_acc   = wren_q & (~full | rden) & ~flush;
   assign drop     = wren_q & full & ~rden & ~flush;
   assign underrun = ~src_sel & wifi_iq_ready & empty & primed_q;

   always_comb begin
      valid1_d = rf_iq_valid;
      wren_d   = valid1_q & ~src_sel;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      primed_d = primed_q;
      hold_d   = hold_q;
      byp_d    = 1'b0;
      ovf_d    = ovf_q;
      unr_d    = unr_q;

      if (drop && (ovf_q != 16'hFFFF)) begin
         ovf_d = ovf_q + 16'd1;
      end
      if (underrun && (unr_q != 16'hFFFF)) begin
         unr_d = unr_q + 16'd1;
      end

      if (flush) begin
         valid1_d = 1'b0;
         wren_d   = 1'b0;
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
         primed_d = 1'b0;
         hold_d   = 1'b0;
      end else begin
         if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
            primed_d = 1'b1;
         end
         if (rden) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
         end
         case ({wr_acc, rden})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
         endcase
         if (count_q >= tx_hold_thr_hi) begin
            hold_d = 1'b1;
         end else if (count_q <= tx_hold_thr_lo) begin
            hold_d = 1'b0;
         end
         // The RAM read returns pre-write data, so a write landing on the next head is forwarded.
         byp_d = wr_acc && (wr_ptr_q == rd_ptr_d);
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         valid1_q <= 1'b0;
         wren_q   <= 1'b0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         primed_q <= 1'b0;
         hold_q   <= 1'b0;
         byp_q    <= 1'b0;
         sel1_q   <= 1'b0;
         sel2_q   <= 1'b0;
         ovf_q    <= '0;
         unr_q    <= '0;
      end else begin
         valid1_q <= valid1_d;
         wren_q   <= wren_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         primed_q <= primed_d;
         hold_q   <= hold_d;
         byp_q    <= byp_d;
         sel1_q   <= src_sel;
         sel2_q   <= sel1_q;
         ovf_q    <= ovf_d;
         unr_q    <= unr_d;
      end
   end

   always_ff @(posedge clk) begin
      wdata_q <= r_all;
   end

   always_ff @(posedge clk) begin
      if (wr_acc) begin
         fifo_mem[wr_ptr_q] <= wdata_q;
      end
      rd_data_q  <= fifo_mem[rd_ptr_d];
      byp_data_q <= wdata_q;
   end

   assign head = byp_q ? byp_data_q : rd_data_q;

   assign wifi_iq_pack         = src_sel ? data_from_s_axis[WW-1:0] : (empty ? '0 : head);
   assign wifi_iq_valid        = src_sel ? emptyn_from_s_axis : 1'b1;
   assign ask_data_from_s_axis = src_sel & wifi_iq_ready;
   assign tx_hold              = hold_q;
   assign tx_iq_fifo_empty     = empty;
   assign data_count           = count_q;
   assign overflow_count       = ovf_q;
   assign underrun_count       = unr_q;

endmodule

// File: tb/tb_tx_iq_intf_mc.sv
// Directed bench for tx_iq_intf_mc: scaling, FWFT latency, hysteresis, overflow, underrun and flush.
module tb_tx_iq_intf_mc;

   logic        clk = 1'b0;
   logic        rstn;
   logic [31:0] rf_i, rf_q;
   logic        rf_iq_valid;
   logic [19:0] bb_gain;
   logic        src_sel;
   logic [63:0] data_from_s_axis;
   logic        emptyn_from_s_axis;
   logic        ask_data_from_s_axis;
   logic [63:0] wifi_iq_pack;
   logic        wifi_iq_valid;
   logic        wifi_iq_ready;
   logic [9:0]  tx_hold_thr_hi, tx_hold_thr_lo;
   logic        tx_hold;
   logic        tx_iq_fifo_empty;
   logic [9:0]  data_count;
   logic [15:0] overflow_count, underrun_count;

   int n_checks = 0;
   int n_fail   = 0;

   tx_iq_intf_mc dut (
      .clk                  (clk),
      .rstn                 (rstn),
      .rf_i                 (rf_i),
      .rf_q                 (rf_q),
      .rf_iq_valid          (rf_iq_valid),
      .bb_gain              (bb_gain),
      .src_sel              (src_sel),
      .data_from_s_axis     (data_from_s_axis),
      .emptyn_from_s_axis   (emptyn_from_s_axis),
      .ask_data_from_s_axis (ask_data_from_s_axis),
      .wifi_iq_pack         (wifi_iq_pack),
      .wifi_iq_valid        (wifi_iq_valid),
      .wifi_iq_ready        (wifi_iq_ready),
      .tx_hold_thr_hi       (tx_hold_thr_hi),
      .tx_hold_thr_lo       (tx_hold_thr_lo),
      .tx_hold              (tx_hold),
      .tx_iq_fifo_empty     (tx_iq_fifo_empty),
      .data_count           (data_count),
      .overflow_count       (overflow_count),
      .underrun_count       (underrun_count)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end else begin
         $display("ok   %s = %h", tag, obs);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic logic [63:0] word(input logic [15:0] i0, input logic [15:0] q0,
                                        input logic [15:0] i1, input logic [15:0] q1);
      return {q1, i1, q0, i0};
   endfunction

   task automatic drive(input logic [15:0] i0, input logic [15:0] q0,
                        input logic [15:0] i1, input logic [15:0] q1);
      rf_i        = {i1, i0};
      rf_q        = {q1, q0};
      rf_iq_valid = 1'b1;
   endtask

   task automatic do_reset;
      rstn        = 1'b0;
      rf_iq_valid = 1'b1;
      cyc(2);
      rstn        = 1'b1;
      rf_iq_valid = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [63:0] exp_w, first_w, last_w;
      logic [15:0] kk;
      int          bad;
      bit          found;

      rstn               = 1'b0;
      rf_i               = '0;
      rf_q               = '0;
      rf_iq_valid        = 1'b0;
      bb_gain            = {10'd128, 10'd128};
      src_sel            = 1'b0;
      data_from_s_axis   = '0;
      emptyn_from_s_axis = 1'b0;
      wifi_iq_ready      = 1'b0;
      tx_hold_thr_hi     = 10'd100;
      tx_hold_thr_lo     = 10'd50;
      cyc(3);

      // Reset state
      do_reset();
      check_val("rst_count",  64'(data_count), 64'd0);
      check_val("rst_empty",  64'(tx_iq_fifo_empty), 64'd1);
      check_val("rst_hold",   64'(tx_hold), 64'd0);
      check_val("rst_ovf",    64'(overflow_count), 64'd0);
      check_val("rst_unr",    64'(underrun_count), 64'd0);
      check_val("rst_pack",   wifi_iq_pack, 64'd0);
      check_val("rst_valid",  64'(wifi_iq_valid), 64'd1);
      check_val("rst_ask",    64'(ask_data_from_s_axis), 64'd0);

      // Unity gain, three-edge latency, FWFT read with ready=1
      wifi_iq_ready = 1'b1;
      drive(16'(1000), 16'(-1000), 16'(-7), 16'(12345));
      cyc(1);
      rf_iq_valid = 1'b0;
      cyc(1);
      check_val("t1_empty_e2", 64'(tx_iq_fifo_empty), 64'd1);
      check_val("t1_pack_e2",  wifi_iq_pack, 64'd0);
      cyc(1);
      check_val("t1_pack_e3",  wifi_iq_pack, 64'hFC18_03E8_3039_FFF9 >> 0 == 0 ? 64'd0 :
                word(16'h03E8, 16'hFC18, 16'hFFF9, 16'h3039));
      check_val("t1_count_e3", 64'(data_count), 64'd1);
      cyc(1);
      check_val("t1_empty_e4", 64'(tx_iq_fifo_empty), 64'd1);
      check_val("t1_unr_e4",   64'(underrun_count), 64'd0);
      cyc(1);
      check_val("t1_unr_e5",   64'(underrun_count), 64'd1);
      wifi_iq_ready = 1'b0;

      // Large gain wrap/saturate, rounding, negative gain, read+write on the same edge
      do_reset();
      wifi_iq_ready = 1'b1;
      bb_gain = {10'd64, 10'd256};
      drive(16'(30000), 16'(-30000), 16'(3), 16'(-3));
      cyc(1);
      bb_gain = {10'h380, 10'd128};
      drive(16'h8000, 16'h7FFF, 16'(100), 16'h8000);
      cyc(1);
      rf_iq_valid = 1'b0;
      cyc(1);
`ifdef TX_IQ_INTF_MC_SAT_EN
      exp_w = word(16'h7FFF, 16'h8000, 16'h0002, 16'hFFFF);
`else
      exp_w = word(16'hEA60, 16'h15A0, 16'h0002, 16'hFFFF);
`endif
      check_val("t2_big_gain", wifi_iq_pack, exp_w);
      cyc(1);
`ifdef TX_IQ_INTF_MC_SAT_EN
      exp_w = word(16'h8000, 16'h7FFF, 16'hFF9C, 16'h7FFF);
`else
      exp_w = word(16'h8000, 16'h7FFF, 16'hFF9C, 16'h8000);
`endif
      check_val("t2_neg_gain", wifi_iq_pack, exp_w);
      check_val("t2_count",    64'(data_count), 64'd1);
      wifi_iq_ready = 1'b0;

      // tx_hold hysteresis
      do_reset();
      bb_gain        = {10'd128, 10'd128};
      tx_hold_thr_hi = 10'd100;
      tx_hold_thr_lo = 10'd50;
      drive(16'(1), 16'(2), 16'(3), 16'(4));
      found = 1'b0;
      for (int c = 0; c < 300 && !found; c++) begin
         cyc(1);
         if (data_count == 10'd100) found = 1'b1;
      end
      check_val("t3_reach_hi", 64'(found), 64'd1);
      check_val("t3_hold_at100", 64'(tx_hold), 64'd0);
      cyc(1);
      check_val("t3_hold_set", 64'(tx_hold), 64'd1);
      rf_iq_valid = 1'b0;
      cyc(3);
      wifi_iq_ready = 1'b1;
      found = 1'b0;
      for (int c = 0; c < 300 && !found; c++) begin
         cyc(1);
         if (data_count == 10'd50) found = 1'b1;
      end
      check_val("t3_reach_lo", 64'(found), 64'd1);
      check_val("t3_hold_at50", 64'(tx_hold), 64'd1);
      cyc(1);
      check_val("t3_hold_clr", 64'(tx_hold), 64'd0);
      check_val("t3_count49",  64'(data_count), 64'd49);
      wifi_iq_ready = 1'b0;

      // Overflow: 520 writes into a 512-deep FIFO, then ordered drain
      do_reset();
      tx_hold_thr_hi = 10'd1023;
      tx_hold_thr_lo = 10'd600;
      for (int k = 0; k < 520; k++) begin
         kk = 16'(k);
         drive(kk, kk + 16'h1000, kk + 16'h2000, kk + 16'h3000);
         cyc(1);
      end
      rf_iq_valid = 1'b0;
      cyc(3);
      check_val("t4_count",  64'(data_count), 64'd512);
      check_val("t4_ovf",    64'(overflow_count), 64'd8);
      check_val("t4_hold",   64'(tx_hold), 64'd0);
      first_w = wifi_iq_pack;
      check_val("t4_head0",  first_w, word(16'h0000, 16'h1000, 16'h2000, 16'h3000));
      wifi_iq_ready = 1'b1;
      bad    = 0;
      last_w = '0;
      for (int k = 0; k < 512; k++) begin
         kk = 16'(k);
         if (wifi_iq_pack !== word(kk, kk + 16'h1000, kk + 16'h2000, kk + 16'h3000)) bad++;
         if (k == 511) last_w = wifi_iq_pack;
         cyc(1);
      end
      check_val("t4_drain_bad", 64'(bad), 64'd0);
      check_val("t4_last",   last_w, word(16'h01FF, 16'h11FF, 16'h21FF, 16'h31FF));
      check_val("t4_empty",  64'(tx_iq_fifo_empty), 64'd1);
      wifi_iq_ready = 1'b0;

      // Underrun after priming
      do_reset();
      drive(16'(5), 16'(6), 16'(7), 16'(8));
      cyc(1);
      rf_iq_valid = 1'b0;
      cyc(2);
      check_val("t5_count1", 64'(data_count), 64'd1);
      wifi_iq_ready = 1'b1;
      cyc(11);
      wifi_iq_ready = 1'b0;
      #1;
      check_val("t5_unr",   64'(underrun_count), 64'd10);
      check_val("t5_pack",  wifi_iq_pack, 64'd0);
      check_val("t5_valid", 64'(wifi_iq_valid), 64'd1);
      check_val("t5_ovf",   64'(overflow_count), 64'd0);

      // Flush on src_sel change, bypass path
      tx_hold_thr_hi = 10'd10;
      tx_hold_thr_lo = 10'd5;
      for (int k = 0; k < 20; k++) begin
         kk = 16'(k);
         drive(kk, kk, kk, kk);
         cyc(1);
      end
      rf_iq_valid = 1'b0;
      cyc(3);
      check_val("t6_count20", 64'(data_count), 64'd20);
      check_val("t6_hold",    64'(tx_hold), 64'd1);
      src_sel            = 1'b1;
      data_from_s_axis   = 64'hDEAD_BEEF_CAFE_F00D;
      emptyn_from_s_axis = 1'b1;
      wifi_iq_ready      = 1'b1;
      #1;
      check_val("t6_ask",    64'(ask_data_from_s_axis), 64'd1);
      check_val("t6_bpack",  wifi_iq_pack, 64'hDEAD_BEEF_CAFE_F00D);
      check_val("t6_bvalid", 64'(wifi_iq_valid), 64'd1);
      cyc(1);
      check_val("t6_noread", 64'(data_count), 64'd20);
      cyc(2);
      check_val("t6_flushed",  64'(tx_iq_fifo_empty), 64'd1);
      check_val("t6_count0",   64'(data_count), 64'd0);
      check_val("t6_hold_clr", 64'(tx_hold), 64'd0);
      wifi_iq_ready = 1'b0;
      #1;
      check_val("t6_ask_lo", 64'(ask_data_from_s_axis), 64'd0);
      emptyn_from_s_axis = 1'b0;
      #1;
      check_val("t6_bvalid_lo", 64'(wifi_iq_valid), 64'd0);
      src_sel       = 1'b0;
      wifi_iq_ready = 1'b1;
      cyc(4);
      check_val("t6_unr_kept", 64'(underrun_count), 64'd10);
      check_val("t6_fvalid",   64'(wifi_iq_valid), 64'd1);
      check_val("t6_fpack",    wifi_iq_pack, 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
